exec_arith_branch_unit: RTL and testbench
=========================================

// Module: exec_arith_branch_unit
// PURPOSE
//  Execute-stage slice covering add/subtract (with carry), absolute value, compare-flag
//  generation and branch resolution. Sits between decode/operand-fetch and writeback.
//  Produces one registered arithmetic result per valid instruction, keeps the CMP
//  condition flags, and resolves jumps combinationally for the fetch redirect.
// PARAMETERS
//  W_OPR  32  operand/result width
//  ADDR   32  PC / branch address width
//  W_IMM  16  immediate width
//  W_OPC  7   opcode width; opecode_i[4:0] selects the operation
// PORTS
//  clk            in   1      clock, rising edge
//  reset          in   1      synchronous, active-low reset
//  v_i            in   1      input instruction valid
//  stall_i        in   1      pipeline stall; holds all registers
//  pc_i           in   ADDR   PC of the current instruction
//  immf_i         in   1      1: second operand = extended imm_i; 0: opr1_i
//  immsign_i      in   1      1: sign-extend imm_i; 0: zero-extend
//  imm_i          in   W_IMM  immediate
//  opecode_i      in   W_OPC  opcode
//  opr0_i         in   W_OPR  operand A
//  opr1_i         in   W_OPR  operand B register value
//  v_o            out  1      result valid (registered)
//  result_o       out  W_OPR  registered result
//  flags_o        out  4      {C,Z,S,V} flag registers
//  branch_o       out  1      take branch (combinational)
//  branch_addr_o  out  ADDR   branch target (combinational)
// BEHAVIOUR
//  - B = immf_i ? ext(imm_i) : opr1_i; ext per immsign_i to W_OPR.
//  - Opcodes by opecode_i[4:0]: 0 ADD A+B; 1 SUB A-B; 4 CMP; 5 ABS |B|; 6 ADC A+B+C;
//    7 SBC A-B-C; 28 J; 29 JA; all other codes give result 0. Results mod 2^32.
//  - ABS: B[31] ? -B : B; 0x8000_0000 returns 0x8000_0000.
//  - CMP computes A-B: C=1 if A<B unsigned (borrow), Z=(A-B==0), S=diff[31],
//    V=(A[31]!=B[31])&&(diff[31]!=A[31]). CMP result_o value is 0.
//  - Flags update only on rising edge with reset=1, ~stall_i, v_i and code 4; else hold.
//  - ADC/SBC use the flag-register C (value before this instruction's edge).
//  - Registered path, latency 1: when ~stall_i: v_o<=v_i, result_o<=selected result.
//    When stall_i=1: v_o, result_o, flags hold.
//  - Branch (J/JA only, combinational): cond by opecode_i[6:5]: 00 always, 01 Z=1,
//    10 Z=0, 11 S!=V. branch_o = v_i & cond. Target: J = pc_i + B, JA = B.
//    branch_addr_o = target even when not taken; 0 for non-jump codes.
//  - Branch uses the registered flags: a CMP in cycle n affects a branch in cycle n+1
//    onward, not the same cycle. branch_o is not masked by stall_i.
//  - Reset (reset=0 at clk edge): v_o=0, result_o=0, flags=0. Overrides stall and
//    in-flight ops; the instruction present at that edge is discarded.
// TESTING
//  - ADD A=5,B=7 v_i=1 -> next cycle v_o=1, result_o=12; SUB 3-5 -> 0xFFFF_FFFE.
//  - immf=1, immsign=1, imm=0xFFFF, ADD A=1 -> 0; immsign=0 -> 0x0001_0000.
//  - ABS B=0xFFFF_FFF6 -> 10; B=0x8000_0000 -> 0x8000_0000; B=0 -> 0.
//  - CMP 3,5 -> flags {C,Z,S,V}=1,0,1,0; next cycle ADC 1+1 -> 3; CMP 0x7FFF_FFFF,
//    0xFFFF_FFFF -> V=1, S=1; CMP with v_i=0 or stall_i=1 -> flags unchanged.
//  - After CMP 4,4: J cond=01, pc=0x100, imm=0x10 -> branch_o=1, addr 0x110; cond=10
//    -> branch_o=0; JA opr1=0x4000 cond=00 -> 1, addr 0x4000; v_i=0 -> branch_o=0.
//  - stall_i=1 for 2 cycles -> result_o/v_o held; reset=0 mid-stall -> all outputs 0.

Source files
------------

// File: rtl/exec_arith_branch_unit_if.sv
// Handshake and data bundle between operand fetch, the execute slice and writeback.
// The master drives the instruction fields; the slave (execute unit) returns results.
interface exec_arith_branch_unit_if #(
    parameter int W_OPR = 32,
    parameter int ADDR  = 32,
    parameter int W_IMM = 16,
    parameter int W_OPC = 7
);
    logic              v_i;
    logic              stall_i;
    logic [ADDR-1:0]   pc_i;
    logic              immf_i;
    logic              immsign_i;
    logic [W_IMM-1:0]  imm_i;
    logic [W_OPC-1:0]  opecode_i;
    logic [W_OPR-1:0]  opr0_i;
    logic [W_OPR-1:0]  opr1_i;
    logic              v_o;
    logic [W_OPR-1:0]  result_o;
    logic [3:0]        flags_o;
    logic              branch_o;
    logic [ADDR-1:0]   branch_addr_o;

    modport master (
        output v_i, stall_i, pc_i, immf_i, immsign_i, imm_i, opecode_i, opr0_i, opr1_i,
        input  v_o, result_o, flags_o, branch_o, branch_addr_o
    );

    modport slave (
        input  v_i, stall_i, pc_i, immf_i, immsign_i, imm_i, opecode_i, opr0_i, opr1_i,
        output v_o, result_o, flags_o, branch_o, branch_addr_o
    );
endinterface

// File: rtl/exec_arith_branch_unit.sv
// Execute-stage slice: add/sub with carry, absolute value, compare flags and
// combinational branch resolution against the registered flags.
module exec_arith_branch_unit #(
    parameter int W_OPR = 32,
    parameter int ADDR  = 32,
    parameter int W_IMM = 16,
    parameter int W_OPC = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    exec_arith_branch_unit_if.slave bus
);
    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_CMP = 5'd4;
    localparam logic [4:0] OP_ABS = 5'd5;
    localparam logic [4:0] OP_ADC = 5'd6;
    localparam logic [4:0] OP_SBC = 5'd7;
    localparam logic [4:0] OP_J   = 5'd28;
    localparam logic [4:0] OP_JA  = 5'd29;

    logic             v_q, v_d;
    logic [W_OPR-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;   // {C,Z,S,V}

    logic [4:0]       op;
    logic [W_OPR-1:0] a, b;
    logic [W_OPR:0]   diff_ext;
    logic [W_OPR-1:0] diff;
    logic [W_OPR-1:0] carry_in;
    logic [3:0]       cmp_flags;
    logic             is_jump;
    logic             cond;

    always_comb begin
        op = bus.opecode_i[4:0];
        a  = bus.opr0_i;
        if (!bus.immf_i)
            b = bus.opr1_i;
        else if (bus.immsign_i)
            b = {{(W_OPR-W_IMM){bus.imm_i[W_IMM-1]}}, bus.imm_i};
        else
            b = {{(W_OPR-W_IMM){1'b0}}, bus.imm_i};

        // The extra top bit of the widened difference is the unsigned borrow.
        diff_ext  = {1'b0, a} - {1'b0, b};
        diff      = diff_ext[W_OPR-1:0];
        carry_in  = {{(W_OPR-1){1'b0}}, flags_q[3]};
        cmp_flags = {diff_ext[W_OPR],
                     (diff == '0),
                     diff[W_OPR-1],
                     (a[W_OPR-1] != b[W_OPR-1]) && (diff[W_OPR-1] != a[W_OPR-1])};

        case (op)
            OP_ADD:  result_d = a + b;
            OP_SUB:  result_d = diff;
            OP_ABS:  result_d = b[W_OPR-1] ? (~b + 1'b1) : b;
            OP_ADC:  result_d = a + b + carry_in;
            OP_SBC:  result_d = diff - carry_in;
            default: result_d = '0;
        endcase

        v_d     = bus.v_i;
        flags_d = (bus.v_i && op == OP_CMP) ? cmp_flags : flags_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            v_q      <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else if (!bus.stall_i) begin
            v_q      <= v_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    // Branches see only flags already registered, never a CMP issued in the same cycle.
    always_comb begin
        is_jump = (op == OP_J) || (op == OP_JA);
        case (bus.opecode_i[6:5])
            2'b00:   cond = 1'b1;
            2'b01:   cond = flags_q[2];
            2'b10:   cond = !flags_q[2];
            default: cond = flags_q[1] != flags_q[0];
        endcase
        bus.branch_o = bus.v_i && is_jump && cond;
        if (op == OP_J)
            bus.branch_addr_o = bus.pc_i + ADDR'(b);
        else if (op == OP_JA)
            bus.branch_addr_o = ADDR'(b);
        else
            bus.branch_addr_o = '0;
    end

    assign bus.v_o      = v_q;
    assign bus.result_o = result_q;
    assign bus.flags_o  = flags_q;
endmodule

// File: tb/tb_exec_arith_branch_unit.sv
// Randomized and directed bench for exec_arith_branch_unit, checked against an
// arithmetic reference model of the instruction set.
module tb_exec_arith_branch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    exec_arith_branch_unit_if #(.W_OPR(32), .ADDR(32), .W_IMM(16), .W_OPC(7)) bus ();

    exec_arith_branch_unit #(.W_OPR(32), .ADDR(32), .W_IMM(16), .W_OPC(7)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_b(input logic immf, input logic ims,
                                          input logic [15:0] imm, input logic [31:0] r1);
        longint x;
        if (!immf) return r1;
        x = ims ? longint'($signed(imm)) : longint'(imm);
        return x[31:0];
    endfunction

    function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic c);
        longint unsigned ua = a, ub = b, uc = c, r;
        case (op)
            5'd0:    r = ua + ub;
            5'd1:    r = ua - ub;
            5'd5:    r = b[31] ? (64'h1_0000_0000 - ub) : ub;
            5'd6:    r = ua + ub + uc;
            5'd7:    r = ua - ub - uc;
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    function automatic logic [3:0] ref_cmp(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        longint sd;
        d  = a - b;
        sd = longint'($signed(a)) - longint'($signed(b));
        return {a < b, a == b, d[31], (sd > 64'sd2147483647) || (sd < -64'sd2147483648)};
    endfunction

    logic        m_v = 1'b0;
    logic [31:0] m_res = '0;
    logic [3:0]  m_flags = '0;
    bit          model_ready = 1'b0;

    always @(posedge clk) begin
        logic [31:0] b;
        b = ref_b(bus.immf_i, bus.immsign_i, bus.imm_i, bus.opr1_i);
        if (!rst_n) begin
            m_v <= 1'b0; m_res <= '0; m_flags <= '0;
        end else if (!bus.stall_i) begin
            m_v   <= bus.v_i;
            m_res <= ref_res(bus.opecode_i[4:0], bus.opr0_i, b, m_flags[3]);
            if (bus.v_i && bus.opecode_i[4:0] == 5'd4)
                m_flags <= ref_cmp(bus.opr0_i, b);
        end
        model_ready <= 1'b1;
    end

    // Single compare process: registered outputs and combinational branch, mid-cycle.
    always @(negedge clk) begin
        logic [31:0] b, tgt;
        logic jmp, cnd;
        if (model_ready) begin
            b   = ref_b(bus.immf_i, bus.immsign_i, bus.imm_i, bus.opr1_i);
            jmp = bus.opecode_i[4:0] == 5'd28 || bus.opecode_i[4:0] == 5'd29;
            case (bus.opecode_i[6:5])
                2'd0: cnd = 1'b1;
                2'd1: cnd = m_flags[2];
                2'd2: cnd = !m_flags[2];
                default: cnd = m_flags[1] ^ m_flags[0];
            endcase
            tgt = !jmp ? 32'd0 : (bus.opecode_i[4:0] == 5'd28 ? bus.pc_i + b : b);
            check("v_o", 64'(bus.v_o), 64'(m_v));
            check("result_o", 64'(bus.result_o), 64'(m_res));
            check("flags_o", 64'(bus.flags_o), 64'(m_flags));
            check("branch_o", 64'(bus.branch_o), 64'(bus.v_i && jmp && cnd));
            check("branch_addr_o", 64'(bus.branch_addr_o), 64'(tgt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic st, input logic [6:0] opc,
                         input logic [31:0] a, input logic [31:0] b1, input logic immf,
                         input logic ims, input logic [15:0] imm, input logic [31:0] pc);
        bus.v_i = v; bus.stall_i = st; bus.opecode_i = opc; bus.opr0_i = a;
        bus.opr1_i = b1; bus.immf_i = immf; bus.immsign_i = ims; bus.imm_i = imm;
        bus.pc_i = pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [4:0] codes [0:8];
        codes = '{5'd0, 5'd1, 5'd4, 5'd5, 5'd6, 5'd7, 5'd28, 5'd29, 5'd12};
        drive(0, 0, 7'd0, 0, 0, 0, 0, 16'h0, 0);
        step(); step();
        check("reset v_o", 64'(bus.v_o), 64'd0);
        check("reset result_o", 64'(bus.result_o), 64'd0);
        check("reset flags_o", 64'(bus.flags_o), 64'd0);
        rst_n = 1'b1;

        drive(1, 0, 7'd0, 32'd5, 32'd7, 0, 0, 16'h0, 0); step();
        check("ADD 5+7", 64'(bus.result_o), 64'd12);
        check("ADD v_o", 64'(bus.v_o), 64'd1);
        drive(1, 0, 7'd1, 32'd3, 32'd5, 0, 0, 16'h0, 0); step();
        check("SUB 3-5", 64'(bus.result_o), 64'hFFFF_FFFE);
        drive(1, 0, 7'd0, 32'd1, 32'd0, 1, 1, 16'hFFFF, 0); step();
        check("ADD sext imm", 64'(bus.result_o), 64'd0);
        drive(1, 0, 7'd0, 32'd1, 32'd0, 1, 0, 16'hFFFF, 0); step();
        check("ADD zext imm", 64'(bus.result_o), 64'h1_0000);
        drive(1, 0, 7'd5, 0, 32'hFFFF_FFF6, 0, 0, 16'h0, 0); step();
        check("ABS -10", 64'(bus.result_o), 64'd10);
        drive(1, 0, 7'd5, 0, 32'h8000_0000, 0, 0, 16'h0, 0); step();
        check("ABS min", 64'(bus.result_o), 64'h8000_0000);
        drive(1, 0, 7'd5, 0, 32'h0, 0, 0, 16'h0, 0); step();
        check("ABS 0", 64'(bus.result_o), 64'd0);
        drive(1, 0, 7'd4, 32'd3, 32'd5, 0, 0, 16'h0, 0); step();
        check("CMP 3,5 flags", 64'(bus.flags_o), 64'b1010);
        check("CMP result", 64'(bus.result_o), 64'd0);
        drive(1, 0, 7'd6, 32'd1, 32'd1, 0, 0, 16'h0, 0); step();
        check("ADC 1+1+C", 64'(bus.result_o), 64'd3);
        drive(1, 0, 7'd4, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 0, 16'h0, 0); step();
        check("CMP ovf flags", 64'(bus.flags_o), 64'b1011);
        drive(0, 0, 7'd4, 32'd4, 32'd4, 0, 0, 16'h0, 0); step();
        check("CMP v_i=0 hold", 64'(bus.flags_o), 64'b1011);
        drive(1, 1, 7'd4, 32'd4, 32'd4, 0, 0, 16'h0, 0); step();
        check("CMP stall hold", 64'(bus.flags_o), 64'b1011);
        drive(1, 0, 7'd4, 32'd4, 32'd4, 0, 0, 16'h0, 0); step();
        check("CMP 4,4 flags", 64'(bus.flags_o), 64'b0100);

        drive(1, 0, {2'b01, 5'd28}, 0, 0, 1, 0, 16'h0010, 32'h100); #1;
        check("J Z=1 taken", 64'(bus.branch_o), 64'd1);
        check("J target", 64'(bus.branch_addr_o), 64'h110);
        step();
        drive(1, 0, {2'b10, 5'd28}, 0, 0, 1, 0, 16'h0010, 32'h100); #1;
        check("J Z=0 not taken", 64'(bus.branch_o), 64'd0);
        check("J target not taken", 64'(bus.branch_addr_o), 64'h110);
        step();
        drive(1, 0, {2'b00, 5'd29}, 0, 32'h4000, 0, 0, 16'h0, 32'h100); #1;
        check("JA taken", 64'(bus.branch_o), 64'd1);
        check("JA target", 64'(bus.branch_addr_o), 64'h4000);
        step();
        drive(0, 0, {2'b00, 5'd29}, 0, 32'h4000, 0, 0, 16'h0, 32'h100); #1;
        check("JA v_i=0", 64'(bus.branch_o), 64'd0);
        step();

        drive(1, 0, 7'd0, 32'd5, 32'd7, 0, 0, 16'h0, 0); step();
        drive(1, 1, 7'd0, 32'd1, 32'd1, 0, 0, 16'h0, 0); step();
        check("stall1 result", 64'(bus.result_o), 64'd12);
        check("stall1 v_o", 64'(bus.v_o), 64'd1);
        step();
        check("stall2 result", 64'(bus.result_o), 64'd12);
        rst_n = 1'b0; step();
        check("reset mid-stall result", 64'(bus.result_o), 64'd0);
        check("reset mid-stall v_o", 64'(bus.v_o), 64'd0);
        check("reset mid-stall flags", 64'(bus.flags_o), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            logic [6:0] opc;
            opc   = {2'($urandom_range(0, 3)), codes[$urandom_range(0, 8)]};
            rst_n = ($urandom_range(0, 99) >= 2);
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 99) < 15, opc, rnd32(), rnd32(),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), $urandom);
            step();
        end
        rst_n = 1'b1;
        drive(0, 0, 7'd0, 0, 0, 0, 0, 16'h0, 0);
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
